// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - inter-stage pipeline register with 2-entry skid buffer, flush and target LSB clear
module pipe_stage_skid_reg #(
  parameter int DATA_W   = 96,
  parameter int CTRL_W   = 16,
  parameter int TGT_W    = 32,
  parameter int CLR_LSBS = 1
) (
  input  logic              clk_in,
  input  logic              reset_n_in,
  input  logic              flush_in,
  input  logic              up_valid_in,
  output logic              up_ready_out,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [TGT_W-1:0]  tgt_in,
  input  logic              tgt_clr_in,
  output logic              down_valid_out,
  input  logic              down_ready_in,
  output logic [DATA_W-1:0] data_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [TGT_W-1:0]  tgt_out,
  output logic [1:0]        occupancy_out
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [TGT_W-1:0]    tgt_q, tgt_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [TGT_W-1:0]    skid_tgt_q, skid_tgt_d;
  logic                up_ready_q, up_ready_d;

  logic [TGT_W-1:0]    clr_mask;
  logic [TGT_W-1:0]    tgt_cap;
  logic                acc;
  logic                rel;

  // Mask of the target bits that are cleared on capture.
  for (genvar g = 0; g < TGT_W; g++) begin : g_clr_mask
    assign clr_mask[g] = (g < CLR_LSBS);
  end

  assign tgt_cap = tgt_clr_in ? (tgt_in & ~clr_mask) : tgt_in;

  // Ready is a flop, so acceptance never depends combinationally on downstream.
  assign acc = up_valid_in & up_ready_q;
  assign rel = down_valid_out & down_ready_in;

  assign up_ready_out   = up_ready_q;
  assign down_valid_out = (state_q != S_EMPTY);
  assign occupancy_out  = state_q;
  assign data_out       = data_q;
  assign ctrl_out       = ctrl_q;
  assign tgt_out        = tgt_q;

  // Next-state: move beats between main and skid; flush overrides everything.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    ctrl_d      = ctrl_q;
    tgt_d       = tgt_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_tgt_d  = skid_tgt_q;

    if (flush_in) begin
      // Incoming beat is dropped; data/target keep their last values.
      state_d     = S_EMPTY;
      ctrl_d      = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (acc) begin
            state_d = S_ONE;
            data_d  = data_in;
            ctrl_d  = ctrl_in;
            tgt_d   = tgt_cap;
          end
        end
        S_ONE: begin
          if (acc && rel) begin
            data_d = data_in;
            ctrl_d = ctrl_in;
            tgt_d  = tgt_cap;
          end else if (acc) begin
            state_d     = S_FULL;
            skid_data_d = data_in;
            skid_ctrl_d = ctrl_in;
            skid_tgt_d  = tgt_cap;
          end else if (rel) begin
            state_d = S_EMPTY;
            ctrl_d  = '0;
          end
        end
        S_FULL: begin
          // Skid beat was already target-cleared at capture; copy as-is.
          if (rel) begin
            state_d     = S_ONE;
            data_d      = skid_data_q;
            ctrl_d      = skid_ctrl_q;
            tgt_d       = skid_tgt_q;
            skid_ctrl_d = '0;
          end
        end
        default: begin
          state_d = S_EMPTY;
          ctrl_d  = '0;
        end
      endcase
    end

    up_ready_d = (state_d != S_FULL);
  end

  // State and storage registers, cleared asynchronously.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q     <= S_EMPTY;
      data_q      <= '0;
      ctrl_q      <= '0;
      tgt_q       <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_tgt_q  <= '0;
      up_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      ctrl_q      <= ctrl_d;
      tgt_q       <= tgt_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_tgt_q  <= skid_tgt_d;
      up_ready_q  <= up_ready_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb/tb_pipe_stage_skid_reg.sv - scoreboard bench for pipe_stage_skid_reg
module tb_pipe_stage_skid_reg;

  typedef struct packed {
    logic [95:0] d;
    logic [15:0] c;
    logic [31:0] t;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        up_valid;
  logic        up_ready;
  logic [95:0] data_i;
  logic [15:0] ctrl_i;
  logic [31:0] tgt_i;
  logic        tgt_clr;
  logic        down_valid;
  logic        down_ready;
  logic [95:0] data_o;
  logic [15:0] ctrl_o;
  logic [31:0] tgt_o;
  logic [1:0]  occ;

  logic        s_valid;
  logic        s_up_ready;
  logic [7:0]  s_data_i;
  logic [0:0]  s_ctrl_i;
  logic [15:0] s_tgt_i;
  logic        s_clr;
  logic        s_down_valid;
  logic [7:0]  s_data_o;
  logic [0:0]  s_ctrl_o;
  logic [15:0] s_tgt_o;
  logic [1:0]  s_occ;

  int checks = 0;
  int errors = 0;
  beat_t exp_q[$];

  pipe_stage_skid_reg u_dut (
    .clk_in         (clk),
    .reset_n_in     (rst_n),
    .flush_in       (flush),
    .up_valid_in    (up_valid),
    .up_ready_out   (up_ready),
    .data_in        (data_i),
    .ctrl_in        (ctrl_i),
    .tgt_in         (tgt_i),
    .tgt_clr_in     (tgt_clr),
    .down_valid_out (down_valid),
    .down_ready_in  (down_ready),
    .data_out       (data_o),
    .ctrl_out       (ctrl_o),
    .tgt_out        (tgt_o),
    .occupancy_out  (occ)
  );

  pipe_stage_skid_reg #(
    .DATA_W   (8),
    .CTRL_W   (1),
    .TGT_W    (16),
    .CLR_LSBS (2)
  ) u_small (
    .clk_in         (clk),
    .reset_n_in     (rst_n),
    .flush_in       (1'b0),
    .up_valid_in    (s_valid),
    .up_ready_out   (s_up_ready),
    .data_in        (s_data_i),
    .ctrl_in        (s_ctrl_i),
    .tgt_in         (s_tgt_i),
    .tgt_clr_in     (s_clr),
    .down_valid_out (s_down_valid),
    .down_ready_in  (1'b1),
    .data_out       (s_data_o),
    .ctrl_out       (s_ctrl_o),
    .tgt_out        (s_tgt_o),
    .occupancy_out  (s_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [95:0] d, input logic [15:0] c,
                       input logic [31:0] t, input logic clr);
    up_valid = v;
    data_i   = d;
    ctrl_i   = c;
    tgt_i    = t;
    tgt_clr  = clr;
  endtask

  task automatic expect_beat(input logic [95:0] d, input logic [15:0] c, input logic [31:0] t);
    beat_t b;
    b.d = d;
    b.c = c;
    b.t = t;
    exp_q.push_back(b);
  endtask

  // Monitor: pops on every downstream handshake, checks bubbles and hold stability.
  logic        prev_hold = 1'b0;
  beat_t       held;
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (!down_valid) check("bubble_ctrl", 96'(ctrl_o), 96'h0);
      if (prev_hold && down_valid) begin
        check("hold_data", data_o, held.d);
        check("hold_ctrl", 96'(ctrl_o), 96'(held.c));
        check("hold_tgt",  96'(tgt_o), 96'(held.t));
      end
      if (down_valid && down_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", data_o, 96'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", data_o, e.d);
          check("sb_ctrl", 96'(ctrl_o), 96'(e.c));
          check("sb_tgt",  96'(tgt_o), 96'(e.t));
        end
      end
      prev_hold = down_valid && !down_ready;
      held.d = data_o;
      held.c = ctrl_o;
      held.t = tgt_o;
    end
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    down_ready = 1'b0;
    drive(1'b0, 96'h0, 16'h0, 32'h0, 1'b0);
    s_valid = 1'b0; s_data_i = 8'h0; s_ctrl_i = 1'b0; s_tgt_i = 16'h0; s_clr = 1'b0;
    step();
    step();
    check("rst_valid", 96'(down_valid), 96'h0);
    check("rst_occ",   96'(occ), 96'h0);
    check("rst_ready", 96'(up_ready), 96'h1);
    check("rst_data",  data_o, 96'h0);
    check("rst_ctrl",  96'(ctrl_o), 96'h0);
    check("rst_tgt",   96'(tgt_o), 96'h0);
    rst_n = 1'b1;
    step();

    // Single beat with target clear.
    down_ready = 1'b1;
    drive(1'b1, 96'h123, 16'h00A5, 32'h1003, 1'b1);
    expect_beat(96'h123, 16'h00A5, 32'h1002);
    step();
    drive(1'b0, 96'h0, 16'h0, 32'h0, 1'b0);
    check("single_valid", 96'(down_valid), 96'h1);
    check("single_tgt",   96'(tgt_o), 96'h1002);
    step();
    check("single_drain_valid", 96'(down_valid), 96'h0);
    check("single_drain_ctrl",  96'(ctrl_o), 96'h0);
    check("single_drain_occ",   96'(occ), 96'h0);

    // Streaming 1..8 at full rate.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 96'(i), 16'(i), 32'(i << 4), 1'b0);
      expect_beat(96'(i), 16'(i), 32'(i << 4));
      step();
      check("stream_occ",   96'(occ), 96'h1);
      check("stream_ready", 96'(up_ready), 96'h1);
      check("stream_data",  data_o, 96'(i));
    end
    drive(1'b0, 96'h0, 16'h0, 32'h0, 1'b0);
    step();
    check("stream_end_occ", 96'(occ), 96'h0);

    // Back-pressure: A, B fill the stage, C waits; B's target cleared in skid.
    down_ready = 1'b0;
    drive(1'b1, 96'hA, 16'h1, 32'h100, 1'b0);
    expect_beat(96'hA, 16'h1, 32'h100);
    step();
    check("bp_occ1", 96'(occ), 96'h1);
    drive(1'b1, 96'hB, 16'h2, 32'h203, 1'b1);
    expect_beat(96'hB, 16'h2, 32'h202);
    step();
    check("bp_occ2",   96'(occ), 96'h2);
    check("bp_ready0", 96'(up_ready), 96'h0);
    check("bp_headA",  data_o, 96'hA);
    drive(1'b1, 96'hC, 16'h3, 32'h300, 1'b0);
    expect_beat(96'hC, 16'h3, 32'h300);
    step();
    check("bp_c_blocked_occ", 96'(occ), 96'h2);
    check("bp_c_blocked_head", data_o, 96'hA);
    step();
    down_ready = 1'b1;
    step();
    check("bp_after_rel_occ",   96'(occ), 96'h1);
    check("bp_after_rel_ready", 96'(up_ready), 96'h1);
    check("bp_after_rel_head",  data_o, 96'hB);
    step();
    drive(1'b0, 96'h0, 16'h0, 32'h0, 1'b0);
    check("bp_c_head", data_o, 96'hC);
    step();
    check("bp_end_occ", 96'(occ), 96'h0);

    // Flush while full; the held beats and 0x55 are discarded.
    down_ready = 1'b0;
    drive(1'b1, 96'h31, 16'h11, 32'h0, 1'b0);
    step();
    drive(1'b1, 96'h32, 16'h12, 32'h0, 1'b0);
    step();
    check("fl_occ2", 96'(occ), 96'h2);
    flush = 1'b1;
    drive(1'b1, 96'h55, 16'h55, 32'h55, 1'b0);
    step();
    flush = 1'b0;
    drive(1'b0, 96'h0, 16'h0, 32'h0, 1'b0);
    check("fl_valid", 96'(down_valid), 96'h0);
    check("fl_ctrl",  96'(ctrl_o), 96'h0);
    check("fl_occ",   96'(occ), 96'h0);
    check("fl_ready", 96'(up_ready), 96'h1);
    check("fl_data_kept", data_o, 96'h31);
    down_ready = 1'b1;
    step();
    step();
    check("fl_still_empty", 96'(occ), 96'h0);

    // Asynchronous reset between edges while full.
    down_ready = 1'b0;
    drive(1'b1, 96'h41, 16'h21, 32'h41, 1'b0);
    step();
    drive(1'b1, 96'h42, 16'h22, 32'h42, 1'b0);
    step();
    drive(1'b0, 96'h0, 16'h0, 32'h0, 1'b0);
    check("ar_occ2", 96'(occ), 96'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 96'(down_valid), 96'h0);
    check("ar_occ",   96'(occ), 96'h0);
    check("ar_ready", 96'(up_ready), 96'h1);
    check("ar_data",  data_o, 96'h0);
    check("ar_ctrl",  96'(ctrl_o), 96'h0);
    check("ar_tgt",   96'(tgt_o), 96'h0);
    step();
    rst_n = 1'b1;
    down_ready = 1'b1;
    drive(1'b1, 96'h77, 16'h7, 32'h70, 1'b0);
    expect_beat(96'h77, 16'h7, 32'h70);
    step();
    drive(1'b0, 96'h0, 16'h0, 32'h0, 1'b0);
    check("ar_lat_valid", 96'(down_valid), 96'h1);
    check("ar_lat_data",  data_o, 96'h77);
    step();

    // Narrow instance, two LSBs cleared.
    s_valid = 1'b1; s_data_i = 8'h5A; s_ctrl_i = 1'b1; s_tgt_i = 16'hFFFF; s_clr = 1'b1;
    step();
    check("sm_tgt_clr",  96'(s_tgt_o), 96'hFFFC);
    check("sm_valid",    96'(s_down_valid), 96'h1);
    check("sm_data",     96'(s_data_o), 96'h5A);
    s_clr = 1'b0;
    step();
    check("sm_tgt_keep", 96'(s_tgt_o), 96'hFFFF);
    s_valid = 1'b0;
    step();
    check("sm_bubble_ctrl", 96'(s_ctrl_o), 96'h0);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    check("sb_drained", 96'(exp_q.size()), 96'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
